// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit for the EX stage: multi-cycle MULT/MULTU and
// restoring radix-2 DIV/DIVU, plus MTHI/MTLO writes and a combinational HI/LO read.
module hilo_mdu #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_flush,
  input  logic        i_hilo_sel,
  output logic        o_busy,
  output logic [31:0] o_RHLOut
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_opa, r_opb;   // MUL: operands; DIV: quotient shift reg / divisor
  logic [31:0] r_rem;
  logic        r_sgn, r_sa, r_sb, r_dz, r_busy;

  logic [63:0] w_ax, w_bx, w_prod;
  logic [32:0] w_trial;
  logic [31:0] w_quo_fix, w_rem_fix, w_mag_a, w_mag_b;
  logic        w_sa, w_sb;

  // Sign-extend only for MULT; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign w_ax   = {{32{r_sgn & r_opa[31]}}, r_opa};
  assign w_bx   = {{32{r_sgn & r_opb[31]}}, r_opb};
  assign w_prod = w_ax * w_bx;

  assign w_sa    = ~i_op[0] & i_A[31];
  assign w_sb    = ~i_op[0] & i_B[31];
  assign w_mag_a = w_sa ? (32'd0 - i_A) : i_A;
  assign w_mag_b = w_sb ? (32'd0 - i_B) : i_B;

  assign w_trial   = {r_rem, r_opa[31]} - {1'b0, r_opb};
  assign w_quo_fix = (r_sa ^ r_sb) ? (32'd0 - r_opa) : r_opa;
  assign w_rem_fix = r_sa ? (32'd0 - r_rem) : r_rem;

  assign o_busy   = r_busy;
  assign o_RHLOut = i_hilo_sel ? r_hi : r_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_rem   <= '0;
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_flush) begin
            case (i_op)
              3'b000, 3'b001: begin
                r_opa   <= i_A;
                r_opb   <= i_B;
                r_sgn   <= ~i_op[0];
                r_cnt   <= 6'd1;
                r_state <= S_MUL;
                r_busy  <= 1'b1;
              end
              3'b010, 3'b011: begin
                r_opa   <= w_mag_a;
                r_opb   <= w_mag_b;
                r_rem   <= '0;
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_dz    <= (i_B == 32'd0);
                r_cnt   <= '0;
                r_state <= S_DIV;
                r_busy  <= 1'b1;
              end
              3'b100:  r_hi <= i_A;
              3'b101:  r_lo <= i_A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 6'(MUL_CYCLES)) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DIV: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // One restoring step: keep the trial remainder if it did not go negative.
            if (!w_trial[32]) begin
              r_rem <= w_trial[31:0];
              r_opa <= {r_opa[30:0], 1'b1};
            end else begin
              r_rem <= {r_rem[30:0], r_opa[31]};
              r_opa <= {r_opa[30:0], 1'b0};
            end
            if (r_cnt == 6'd31) r_state <= S_FIX;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX: begin
          if (!i_flush && !r_dz) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
